// File: rtl/seq_factorial_engine.sv
// -----------------------------------------------------------------------------
// seq_factorial_engine
//
// Multi-cycle factorial unit. An unsigned operand is captured on a start
// handshake and the accumulator is multiplied by a down-counter once per
// clock until the counter reaches 1. The result is published with a
// one-cycle done pulse together with an overflow flag.
//
// Optional build macro:
//   FACT_EARLY_ABORT_EN - when defined, the operation stops on the first
//                         partial product that does not fit in RES_WIDTH bits.
//                         done pulses on that edge, overflow=1 and result is
//                         saturated to all ones. When undefined, iteration
//                         always runs to completion and result = n! mod
//                         2^RES_WIDTH.
//
// Parameters:
//   N_WIDTH   - operand width (operand range 0 .. 2^N_WIDTH-1)
//   RES_WIDTH - result width, must be >= N_WIDTH
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request, sampled only while ready=1
//   num      in   operand, captured on the accepting edge
//   abort    in   cancels an in-flight computation (no done pulse)
//   ready    out  high in IDLE
//   busy     out  high in CALC
//   done     out  one-cycle pulse, result/overflow valid
//   result   out  n! (or its overflow variant), held until next accept
//   overflow out  a partial product exceeded RES_WIDTH bits
// -----------------------------------------------------------------------------
module seq_factorial_engine #(
    parameter int N_WIDTH   = 8,
    parameter int RES_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_WIDTH-1:0]   num,
    input  logic                 abort,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [RES_WIDTH-1:0] result,
    output logic                 overflow
);

    localparam int P_WIDTH = RES_WIDTH + N_WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t                 r_state;
    logic [RES_WIDTH-1:0]   r_acc;
    logic [N_WIDTH-1:0]     r_cnt;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
    logic [RES_WIDTH-1:0]   r_result;
    logic                   r_overflow;

    // Full-width product: the bits above RES_WIDTH tell us whether this step
    // overflowed, the low bits are the truncated next accumulator value.
    logic [P_WIDTH-1:0]     w_prod;
    logic                   w_prod_ovf;
    logic                   w_last;

    assign w_prod     = P_WIDTH'(r_acc) * P_WIDTH'(r_cnt);
    assign w_prod_ovf = |w_prod[P_WIDTH-1:RES_WIDTH];
    // cnt of 0 or 1 means no multiply is left; this makes 0! and 1! finish
    // one edge after acceptance with acc still at 1.
    assign w_last     = (r_cnt <= N_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            // done is a pulse: only the completing edge below re-asserts it.
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_CALC;
                        r_acc      <= RES_WIDTH'(1);
                        r_cnt      <= num;
                        r_overflow <= 1'b0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                S_CALC: begin
                    if (abort) begin
                        // Cancel: result is left untouched, no done pulse.
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_last) begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_result <= r_acc;
                        r_done   <= 1'b1;
                    end else begin
`ifdef FACT_EARLY_ABORT_EN
                        if (w_prod_ovf) begin
                            // First overflowing step ends the operation with
                            // a saturated result.
                            r_state    <= S_IDLE;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_result   <= '1;
                            r_overflow <= 1'b1;
                            r_done     <= 1'b1;
                        end else begin
                            r_acc <= w_prod[RES_WIDTH-1:0];
                            r_cnt <= r_cnt - N_WIDTH'(1);
                        end
`else
                        r_acc <= w_prod[RES_WIDTH-1:0];
                        r_cnt <= r_cnt - N_WIDTH'(1);
                        // Sticky for the rest of the operation.
                        if (w_prod_ovf) begin
                            r_overflow <= 1'b1;
                        end
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_seq_factorial_engine.sv
// -----------------------------------------------------------------------------
// Testbench for seq_factorial_engine. Two instances: the default 8/32 build
// and a narrow 4/16 build. Expected results, overflow and latency come from a
// plain-arithmetic factorial model.
// -----------------------------------------------------------------------------
module tb_seq_factorial_engine;

    logic clk;
    logic rst;

    // 8/32 instance
    logic        a_start, a_abort;
    logic [7:0]  a_num;
    logic        a_ready, a_busy, a_done, a_overflow;
    logic [31:0] a_result;

    // 4/16 instance
    logic        b_start, b_abort;
    logic [3:0]  b_num;
    logic        b_ready, b_busy, b_done, b_overflow;
    logic [15:0] b_result;

    int n_cmp  = 0;
    int n_fail = 0;
    int sel    = 0;           // 0 -> 8/32 instance, 1 -> 4/16 instance
    logic [63:0] exp_last = '0;

    logic        cur_ready, cur_busy, cur_done, cur_ovf;
    logic [63:0] cur_result;

    seq_factorial_engine #(.N_WIDTH(8), .RES_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .num(a_num), .abort(a_abort),
        .ready(a_ready), .busy(a_busy), .done(a_done),
        .result(a_result), .overflow(a_overflow)
    );

    seq_factorial_engine #(.N_WIDTH(4), .RES_WIDTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .num(b_num), .abort(b_abort),
        .ready(b_ready), .busy(b_busy), .done(b_done),
        .result(b_result), .overflow(b_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_ready  = a_ready;
        cur_busy   = a_busy;
        cur_done   = a_done;
        cur_ovf    = a_overflow;
        cur_result = {32'd0, a_result};
        if (sel != 0) begin
            cur_ready  = b_ready;
            cur_busy   = b_busy;
            cur_done   = b_done;
            cur_ovf    = b_overflow;
            cur_result = {48'd0, b_result};
        end
    end

    // Reference: n! built from its factors n, n-1, ..., 1 in that order.
    // Overflow is when the exact running product first reaches 2^rw.
    function automatic void model(input int n, input int rw,
                                  output logic [63:0] res, output bit ovf,
                                  output int lat);
        logic [63:0] lim;
        logic [63:0] exact;
        logic [63:0] modp;
        lim   = 64'd1 << rw;
        exact = 64'd1;
        modp  = 64'd1;
        ovf   = 1'b0;
        lat   = (n <= 1) ? 1 : n;
        for (int k = 0; k < n; k++) begin
            modp = (modp * 64'(n - k)) % lim;
            if (!ovf) begin
                exact = exact * 64'(n - k);
                if (exact >= lim) begin
                    ovf = 1'b1;
`ifdef FACT_EARLY_ABORT_EN
                    lat = k + 1;
`endif
                end
            end
        end
        res = modp;
`ifdef FACT_EARLY_ABORT_EN
        if (ovf) res = lim - 64'd1;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input int n);
        if (sel == 0) begin
            a_start = s;
            a_num   = n[7:0];
        end else begin
            b_start = s;
            b_num   = n[3:0];
        end
    endtask

    // Called #1 after a rising edge. Returns #1 after the done edge, so a
    // following call starts the next operation during the done cycle.
    task automatic run_op(input int n, input int glitch_at);
        logic [63:0] eres;
        bit          eovf;
        int          elat;
        int          k;
        bit          got;
        int          rw;
        int          r;
        rw = (sel == 0) ? 32 : 16;
        model(n, rw, eres, eovf, elat);
        check("ready_before", 64'(cur_ready), 64'd1);
        drive(1'b1, n);
        @(posedge clk); #1;
        r = int'($urandom);
        drive(1'b0, r);           // operand changes after accept must not matter
        check("busy_after_accept", 64'(cur_busy), 64'd1);
        k   = 0;
        got = 1'b0;
        while (!got && k < 400) begin
            if (glitch_at > 0 && k == glitch_at)     drive(1'b1, 3);
            if (glitch_at > 0 && k == glitch_at + 1) drive(1'b0, 3);
            @(posedge clk); #1;
            k++;
            if (cur_done) got = 1'b1;
        end
        drive(1'b0, 0);
        check("done_seen", 64'(got), 64'd1);
        check("latency", 64'(k), 64'(elat));
        check("result", cur_result, eres);
        check("overflow", 64'(cur_ovf), 64'(eovf));
        check("ready_at_done", 64'(cur_ready), 64'd1);
        $display("op sel=%0d n=%0d result=%0d ovf=%0d latency=%0d (exp %0d/%0d/%0d)",
                 sel, n, cur_result, cur_ovf, k, eres, eovf, elat);
        exp_last = eres;
    endtask

    // One quiet cycle after an operation: done must drop, result holds.
    task automatic idle_cycle();
        @(posedge clk); #1;
        check("done_pulse_low", 64'(cur_done), 64'd0);
        check("result_held", cur_result, exp_last);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_num = '0;
        b_start = 1'b0; b_abort = 1'b0; b_num = '0;
        #12;
        check("rst_ready", 64'(a_ready), 64'd1);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_result", 64'(a_result), 64'd0);
        check("rst_overflow", 64'(a_overflow), 64'd0);
        #5 rst = 1'b0;
        @(posedge clk); #1;

        // Directed basic operations
        sel = 0;
        run_op(0, 0);  idle_cycle();
        run_op(1, 0);  idle_cycle();
        run_op(5, 0);  idle_cycle();
        run_op(12, 0);
        run_op(13, 0);                 // back-to-back, start during done cycle
        idle_cycle();

        // start while busy is ignored
        run_op(7, 2);  idle_cycle();

        // abort on the 4th CALC cycle
        drive(1'b1, 10);
        @(posedge clk); #1;
        drive(1'b0, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        check("abort_ready", 64'(a_ready), 64'd1);
        check("abort_busy", 64'(a_busy), 64'd0);
        check("abort_done", 64'(a_done), 64'd0);
        check("abort_result", 64'(a_result), 64'd5040);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", 64'(a_done), 64'd0);
        end
        $display("abort n=10 result=%0d ready=%0d", a_result, a_ready);
        run_op(4, 0);  idle_cycle();

        // abort in IDLE has no effect
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        check("idle_abort_ready", 64'(a_ready), 64'd1);
        check("idle_abort_result", 64'(a_result), 64'd24);

        // Random operands, back-to-back
        repeat (6) run_op(int'($urandom_range(0, 20)), 0);
        run_op(int'($urandom_range(21, 255)), 0);
        idle_cycle();

        // Asynchronous reset mid-CALC, between clock edges
        drive(1'b1, 20);
        @(posedge clk); #1;
        drive(1'b0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_ready", 64'(a_ready), 64'd1);
        check("midrst_busy", 64'(a_busy), 64'd0);
        check("midrst_done", 64'(a_done), 64'd0);
        check("midrst_result", 64'(a_result), 64'd0);
        check("midrst_overflow", 64'(a_overflow), 64'd0);
        $display("mid-calc reset ready=%0d busy=%0d result=%0d", a_ready, a_busy, a_result);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_op(3, 0);  idle_cycle();

        // Narrow instance
        sel = 1;
        run_op(8, 0);  idle_cycle();
        run_op(9, 0);  idle_cycle();
        repeat (4) run_op(int'($urandom_range(0, 15)), 0);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_factorial_engine.md
Name: seq_factorial_engine

Overview:
- Parametrised, multi-cycle factorial unit: accepts an unsigned operand on a start handshake and iterates one multiply per clock.
- Returns n! with a one-cycle done pulse and an overflow flag.
- Successor to the combinational factorial demo; replaces it wherever operand width, result width or overflow reporting matter.
- Sits as a leaf compute block behind a simple start/ready control interface.

Parameters:
- N_WIDTH, 8, operand width in bits; operand range 0..2^N_WIDTH-1.
- RES_WIDTH, 32, result width in bits; must be >= N_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- num  input  N_WIDTH  operand; captured on the accepting edge.
- abort  input  1  cancel an in-flight computation.
- ready  output  1  high in IDLE; start is accepted this cycle.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse when result/overflow are valid.
- result  output  RES_WIDTH  n! (or its overflow variant); held until next accept.
- overflow  output  1  set if any partial product exceeded RES_WIDTH bits; held with result.

Behaviour:
- Reset (async, any time, including mid-CALC): state=IDLE, ready=1, busy=0, done=0, result=0, overflow=0, internal acc=0, cnt=0.
- States: IDLE and CALC.
- IDLE with start=1 -> CALC on the next edge. That edge also does acc<=1, cnt<=num, overflow<=0. In IDLE with start=0 nothing changes; result and overflow are held.
- CALC, cnt<=1 -> IDLE. On that edge: result<=acc, done<=1.
- CALC, cnt>1 -> acc<=acc*cnt (truncated to RES_WIDTH), cnt<=cnt-1. Overflow is set if the full (RES_WIDTH+N_WIDTH)-bit product has any bit at or above RES_WIDTH set; overflow is sticky for the operation.
- Latency: done is high exactly max(n,1) edges after the accepting edge. So 0! and 1! take 1 cycle and 5! takes 5.
- done is high for one cycle only. It is driven low on every edge where the CALC->IDLE transition does not occur.
- start while busy=1: ignored, no queuing.
- start in the same cycle that done is high: accepted, since state is IDLE then. Back-to-back operations are legal.
- abort=1 in CALC: -> IDLE next edge, done stays 0, result and overflow keep their previous-operation values. abort in IDLE has no effect. abort has priority over the CALC iteration.
- num changes after the accepting edge have no effect on the in-flight operation.
- Multiply is unsigned; no signed operands.

Optional Feature:
- Macro: FACT_EARLY_ABORT_EN.
- Defined: on the edge where overflow is first detected, the FSM goes to IDLE. On that edge done<=1, overflow<=1 and result<=all ones (saturated), with no further iterations. Latency for overflowing operands is therefore shorter than max(n,1).
- Undefined: iteration runs to completion. result = n! mod 2^RES_WIDTH, overflow=1, latency always max(n,1).

Test Plan:
- rst pulse asynchronously mid-cycle, then release -> ready=1, busy=0, done=0, result=0, overflow=0 immediately on assertion.
- Defaults, start with num=0, then num=1, then num=5 -> result=1, 1, 120. done pulses 1, 1, 5 edges after accept; overflow=0 each time.
- num=12 -> result=479001600, overflow=0, done 12 edges after accept. Then num=13 back-to-back (start held during the done cycle):
  - macro off: result=1932053504, overflow=1, latency 13.
  - macro on: result=32'hFFFFFFFF, overflow=1, done on the first overflowing edge.
- num=7 accepted, start pulsed and num changed to 3 while busy -> ignored; result=5040 after 7 edges.
- num=10 accepted, abort raised on the 4th CALC cycle -> IDLE next edge, done never pulses, result still 5040 from the prior test. A new start with num=4 -> result=24.
- N_WIDTH=4, RES_WIDTH=16, num=8 -> result=40320, overflow=0. Then num=9 -> overflow=1 and, with the macro off, result=362880 mod 65536=35200.
